// File: rtl/bcd_bin_seq_ctrl_if.sv
// Handshake bundle between a packed-BCD producer/consumer and bcd_bin_seq_ctrl.
// master = producer/consumer side, slave = converter side.
interface bcd_bin_seq_ctrl_if #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) ();
  logic                  in_valid;
  logic                  in_ready;
  logic [4*DIGITS-1:0]   bcd_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [BIN_W-1:0]      bin_out;
  logic                  err;
  logic                  busy;

  modport master (
    output in_valid, bcd_in, out_ready,
    input  in_ready, out_valid, bin_out, err, busy
  );

  modport slave (
    input  in_valid, bcd_in, out_ready,
    output in_ready, out_valid, bin_out, err, busy
  );
endinterface

// File: rtl/bcd_bin_seq_ctrl.sv
// Sequential packed-BCD to binary converter: one digit per clock, most-significant digit first.
// Optional macro BCD_SEQ_ERR_EN flags non-decimal digits at acceptance and skips conversion.
module bcd_bin_seq_ctrl #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input logic               clk,
  input logic               rst,
  bcd_bin_seq_ctrl_if.slave bus
);
  localparam int SW = 4 * DIGITS;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [SW-1:0]    sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BIN_W-1:0] acc_q, acc_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic [BIN_W-1:0] acc_step;

`ifdef BCD_SEQ_ERR_EN
  logic             err_q, err_d;

  function automatic logic has_bad_nibble(input logic [SW-1:0] w);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (w[4*i +: 4] > 4'd9) begin
        bad = 1'b1;
      end else begin
        bad = bad;
      end
    end
    return bad;
  endfunction
`endif

  // State, datapath and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      bin_q   <= '0;
`ifdef BCD_SEQ_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      bin_q   <= bin_d;
`ifdef BCD_SEQ_ERR_EN
      err_q   <= err_d;
`endif
    end
  end

  // Next-state and datapath update; results only change when entering DONE
  always_comb begin
    state_d  = state_q;
    sreg_d   = sreg_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    bin_d    = bin_q;
`ifdef BCD_SEQ_ERR_EN
    err_d    = err_q;
`endif
    acc_step = (acc_q << 3) + (acc_q << 1) + BIN_W'(sreg_q[SW-1 -: 4]);

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          sreg_d = bus.bcd_in;
          cnt_d  = '0;
          acc_d  = '0;
`ifdef BCD_SEQ_ERR_EN
          if (has_bad_nibble(bus.bcd_in)) begin
            state_d = DONE;
            bin_d   = '0;
            err_d   = 1'b1;
          end else begin
            state_d = CONV;
          end
`else
          state_d = CONV;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      CONV: begin
        sreg_d = sreg_q << 4;
        cnt_d  = cnt_q + CW'(1);
        acc_d  = acc_step;
        if (cnt_q == CW'(DIGITS - 1)) begin
          state_d = DONE;
          bin_d   = acc_step;
`ifdef BCD_SEQ_ERR_EN
          err_d   = 1'b0;
`endif
        end else begin
          state_d = CONV;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.bin_out   = bin_q;
`ifdef BCD_SEQ_ERR_EN
  assign bus.err       = err_q;
`else
  assign bus.err       = 1'b0;
`endif
endmodule
